// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit for the EX stage. Operands are
// captured on a start strobe; the unit then runs 32 radix-2 iterations
// (shift-add multiply or restoring divide), applies sign/special-case
// correction in one FIX cycle, and pulses done for one cycle. Latency is
// fixed: done is high exactly 34 cycles after the start cycle.
//
// Ports:
//   clk     in   1     clock, rising edge
//   rst_n   in   1     synchronous active-low reset
//   start   in   1     request, sampled only in IDLE
//   op      in   3     RV32M funct3 (MUL..REMU)
//   a, b    in   XLEN  rs1 / rs2 operands, sampled with start
//   flush   in   1     abort current operation, no done produced
//   busy    out  1     high whenever not IDLE
//   done    out  1     one-cycle pulse, result valid
//   result  out  XLEN  final value, held until the next FIX
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_reg;
    logic [2:0]        op_reg;
    logic              sign_a_reg;
    logic              sign_b_reg;
    logic [XLEN-1:0]   opa_reg;      // |a|: multiplier (shifts right) or dividend/quotient (shifts left)
    logic [XLEN-1:0]   opb_reg;      // |b|: multiplicand or divisor
    logic [XLEN-1:0]   a_orig_reg;   // raw a, returned by REM/REMU when b = 0
    logic              b_zero_reg;
    logic              ovf_reg;      // signed -2^31 / -1
    logic [2*XLEN-1:0] acc_reg;      // product, or remainder in the low half
    logic [4:0]        cnt_reg;
    logic              busy_reg;
    logic              done_reg;
    logic [XLEN-1:0]   result_reg;

    // Operand signedness from funct3: MULH, MULHSU, DIV, REM treat a as signed;
    // MULH, DIV, REM treat b as signed.
    logic            signed_a;
    logic            signed_b;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;

    assign signed_a = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    assign signed_b = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    assign abs_a    = (signed_a && a[XLEN-1]) ? (~a + 1'b1) : a;
    assign abs_b    = (signed_b && b[XLEN-1]) ? (~b + 1'b1) : b;

    // Shift-add step: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole accumulator right.
    logic [XLEN:0] mul_sum;
    assign mul_sum = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, (opa_reg[0] ? opb_reg : '0)};

    // Restoring step: bring down the next dividend bit and subtract if it fits.
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_ge;
    logic [XLEN-1:0] rem_next;
    assign div_shift = {acc_reg[XLEN-1:0], opa_reg[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opb_reg};
    assign div_ge    = (div_shift >= {1'b0, opb_reg});
    assign rem_next  = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];

    // Sign correction and special-case selection applied in FIX.
    logic              neg;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_value;

    assign neg      = sign_a_reg ^ sign_b_reg;
    assign prod_fix = neg ? (~acc_reg + 1'b1) : acc_reg;
    assign quot_fix = neg ? (~opa_reg + 1'b1) : opa_reg;
    assign rem_fix  = sign_a_reg ? (~acc_reg[XLEN-1:0] + 1'b1) : acc_reg[XLEN-1:0];

    always_comb begin
        fix_value = '0;
        case (op_reg)
            3'd0:          fix_value = prod_fix[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:          fix_value = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5: begin
                if (b_zero_reg)
                    fix_value = '1;
                else if (ovf_reg)
                    fix_value = {1'b1, {(XLEN-1){1'b0}}};
                else
                    fix_value = quot_fix;
            end
            default: begin
                if (b_zero_reg)
                    fix_value = a_orig_reg;
                else if (ovf_reg)
                    fix_value = '0;
                else
                    fix_value = rem_fix;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            op_reg     <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            opa_reg    <= '0;
            opb_reg    <= '0;
            a_orig_reg <= '0;
            b_zero_reg <= 1'b0;
            ovf_reg    <= 1'b0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            result_reg <= '0;
        end else if (flush) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        state_reg  <= CALC;
                        busy_reg   <= 1'b1;
                        op_reg     <= op;
                        sign_a_reg <= signed_a && a[XLEN-1];
                        sign_b_reg <= signed_b && b[XLEN-1];
                        opa_reg    <= abs_a;
                        opb_reg    <= abs_b;
                        a_orig_reg <= a;
                        b_zero_reg <= (b == '0);
                        ovf_reg    <= op[2] && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                    end
                end
                CALC: begin
                    if (op_reg[2]) begin
                        acc_reg <= {{XLEN{1'b0}}, rem_next};
                        opa_reg <= {opa_reg[XLEN-2:0], div_ge};
                    end else begin
                        acc_reg <= {mul_sum, acc_reg[XLEN-1:1]};
                        opa_reg <= opa_reg >> 1;
                    end
                    cnt_reg <= cnt_reg + 5'd1;
                    if (cnt_reg == 5'd31)
                        state_reg <= FIX;
                end
                FIX: begin
                    result_reg <= fix_value;
                    done_reg   <= 1'b1;
                    state_reg  <= DONE;
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit for the RV32M instructions, placed in the EX stage beside the combinational ALU. It accepts operands on a start strobe and computes over a fixed number of cycles. It holds `busy` so the hazard unit can stall IF/ID/EX, then returns the result with a one-cycle `done` pulse. It takes the operand pair from the same forwarding muxes that feed the ALU and drives the EX result mux when `done` is high.

## Interface
- `XLEN`, 32, operand and result width; only 32 is supported.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `a`  in  32  rs1 operand; sampled with `start`.
- `b`  in  32  rs2 operand; sampled with `start`.
- `flush`  in  1  abort the current operation (branch mispredict or trap).
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  32  final value; held until the next accepted start.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
  - IDLE to CALC: on `start` and not `flush`.
  - CALC to FIX: when the iteration counter reaches 31.
  - FIX to DONE: unconditional.
  - DONE to IDLE: unconditional.
- **Capture at start:**
  - Latch `op` and each operand's sign.
  - Latch the magnitudes |a| and |b|. An operand is signed for MULH and DIV/REM (a and b), and for MULHSU (a only). Otherwise it is unsigned.
  - Clear the 64-bit accumulator/remainder and the 5-bit counter.
- **CALC, multiply:** radix-2 shift-add, one multiplier bit per cycle, LSB first, 32 cycles, producing an unsigned 64-bit product.
- **CALC, divide:** restoring division, one quotient bit per cycle, MSB first, 32 cycles, producing an unsigned quotient and remainder.
- **FIX, multiply:**
  - Negate the 64-bit product if the signs of the signed operands differ.
  - MUL selects bits [31:0]. MULH, MULHSU and MULHU select bits [63:32].
- **FIX, divide:**
  - Negate the quotient if the dividend and divisor signs differ.
  - Give the remainder the dividend's sign.
- **FIX, special cases (override the computed value):**
  - `b`=0: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = original `a` (REM and REMU).
  - Signed overflow, `a`=0x80000000 and `b`=0xFFFFFFFF with DIV/REM: quotient = 0x80000000, remainder = 0.
- **Result register:** `result` is written only in FIX and stays stable through DONE and IDLE.
- **Start while busy:** `start` while not IDLE is ignored. The pipeline must not present it, but the unit tolerates it.

## Timing
- Latency is fixed and independent of operand values or special cases. With `start` sampled high at edge E0:
  - `busy` is high from E0+ through the DONE cycle.
  - `done` is high in the cycle after E33, i.e. exactly 34 cycles after the start cycle.
  - `busy` falls one cycle after `done`.
- **Back-to-back:** a new `start` is accepted on the edge that leaves DONE only if the state is IDLE. The earliest new start is therefore the cycle after `done`.
- **Flush:**
  - `flush` high at any edge forces IDLE.
  - No `done` is produced for the aborted operation.
  - `result` keeps its previous value.
  - `flush` has priority over `start` in the same cycle, and over the DONE-to-IDLE transition (no effect there beyond suppression).
- **Reset:** `rst_n` low at an edge sets the state to IDLE, `busy`=0, `done`=0, `result`=0 and counter=0. This holds mid-operation as well, and reset has priority over `flush` and `start`.
- `done` and `busy` are registered state decodes, not combinational from inputs.

## Test plan
- **Multiply, all variants:** MUL a=7, b=6 gives `done` exactly 34 cycles after start with `result`=42. MULH a=0xFFFFFFFF (-1), b=2 gives 0xFFFFFFFF. MULHU a=0xFFFFFFFF, b=2 gives 0x00000001. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF gives 0xFFFFFFFF.
- **Signed divide:** DIV a=-7 (0xFFFFFFF9), b=2 gives 0xFFFFFFFD (-3). REM with the same operands gives 0xFFFFFFFF (-1). DIVU a=100, b=7 gives 14. REMU with the same operands gives 2.
- **Special cases:**
  - DIV a=5, b=0 gives 0xFFFFFFFF, and REM gives 5.
  - DIV a=0x80000000, b=0xFFFFFFFF gives 0x80000000, and REM gives 0.
  - All of these also take 34 cycles.
- **Flush mid-operation:** start DIV, assert `flush` at cycle 10 so that `busy` drops the next cycle. There must be no `done` in the following 40 cycles, and `result` keeps its old value. A new start then completes normally.
- **Reset mid-operation:** `rst_n`=0 at cycle 20 of a MUL gives `busy`=0, `done`=0 and `result`=0 on the next cycle.
- **Handshake robustness:** hold `start` high continuously with changing operands. Each operation must use the operands sampled in its IDLE cycle, with `done` pulses 35 cycles apart and each `done` exactly one cycle wide.
